// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEX,
    ALUWB, BEQ, ADDIEX, IMMEX, IMMWB, JUMP, BGTZ
  } mc_state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LI    = 6'b010001;
  localparam logic [5:0] OP_BGTZ  = 6'b011101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  typedef struct packed {
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic       memwrite;
    logic       branch;
    logic       branchgt;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       regdst;
    logic       memtoreg;
  } mc_ctrl_t;

endpackage

// File: rtl/mc_outdec.sv
// Moore output decoder: maps the controller state to its control word.
module mc_outdec
  import mips_ctrl_pkg::*;
(
  input  mc_state_t state,
  output mc_ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      FETCH: begin
        ctrl.alusrcb = 2'b01;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
      end
      DECODE: begin
        ctrl.alusrcb = 2'b11;
        ctrl.aluop   = ALUOP_ADD;
      end
      MEMADR, ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.aluop   = ALUOP_ADD;
      end
      MEMRD: ctrl.iord = 1'b1;
      MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      RTEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      IMMEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.aluop   = ALUOP_IMM;
      end
      IMMWB: ctrl.regwrite = 1'b1;
      BEQ: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = 2'b01;
        ctrl.branch  = 1'b1;
      end
      BGTZ: begin
        ctrl.alusrca  = 1'b1;
        ctrl.aluop    = ALUOP_IMM;
        ctrl.pcsrc    = 2'b01;
        ctrl.branchgt = 1'b1;
      end
      JUMP: begin
        ctrl.pcsrc   = 2'b10;
        ctrl.pcwrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS main controller FSM with illegal-opcode flag.
// Optional memory-ready handshake and watchdog enabled by `define MEM_WAIT_EN.
module mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_CYCLES_MAX = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       memready,
  output logic [1:0] aluop,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       branch,
  output logic       branchgt,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       regdst,
  output logic       memtoreg,
  output logic       illop,
  output logic       memtimeout
);

  localparam int CNT_W = (MEM_WAIT_CYCLES_MAX < 2) ? 1 : $clog2(MEM_WAIT_CYCLES_MAX + 1);

  mc_state_t        state_q, state_d;
  logic             illop_q, illop_d;
  logic             memtimeout_q, memtimeout_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             waiting;
  mc_ctrl_t         ctrl;

  mc_outdec u_outdec (
    .state (state_q),
    .ctrl  (ctrl)
  );

  always_comb begin
    state_d      = state_q;
    illop_d      = 1'b0;
    memtimeout_d = memtimeout_q;
    wait_cnt_d   = '0;
    waiting      = 1'b0;
    unique case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        unique case (op)
          OP_LW, OP_SW:           state_d = MEMADR;
          OP_RTYPE:               state_d = RTEX;
          OP_BEQ:                 state_d = BEQ;
          OP_ADDI:                state_d = ADDIEX;
          OP_XORI, OP_LUI, OP_LI: state_d = IMMEX;
          OP_BGTZ:                state_d = BGTZ;
          OP_J:                   state_d = JUMP;
          default: begin
            state_d = FETCH;
            illop_d = 1'b1;
          end
        endcase
      end
      MEMADR: state_d = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  state_d = MEMWB;
      RTEX:   state_d = ALUWB;
      ADDIEX, IMMEX: state_d = IMMWB;
      default: state_d = FETCH;
    endcase
`ifdef MEM_WAIT_EN
    // Memory states stall until memready; the watchdog bails out to FETCH.
    if ((state_q == FETCH || state_q == MEMRD || state_q == MEMWR) && !memready) begin
      waiting    = 1'b1;
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q + 1'b1;
      if (MEM_WAIT_CYCLES_MAX != 0 && wait_cnt_d == CNT_W'(MEM_WAIT_CYCLES_MAX)) begin
        memtimeout_d = 1'b1;
        state_d      = FETCH;
        wait_cnt_d   = '0;
      end
    end
`else
    memtimeout_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= FETCH;
      illop_q      <= 1'b0;
      memtimeout_q <= 1'b0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      illop_q      <= illop_d;
      memtimeout_q <= memtimeout_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

`ifndef MEM_WAIT_EN
  logic unused_mem;
  assign unused_mem = memready ^ (MEM_WAIT_CYCLES_MAX != 0) ^ (|wait_cnt_q);
`endif

  // Strobes drop asynchronously with reset so no partial write can complete.
  logic strobe_en;
  assign strobe_en = reset_n & ~waiting;

  assign irwrite    = ctrl.irwrite  & strobe_en;
  assign pcwrite    = ctrl.pcwrite  & strobe_en;
  assign regwrite   = ctrl.regwrite & strobe_en;
  assign memwrite   = ctrl.memwrite & strobe_en;
  assign branch     = ctrl.branch   & strobe_en;
  assign branchgt   = ctrl.branchgt & strobe_en;
  assign aluop      = ctrl.aluop;
  assign iord       = ctrl.iord;
  assign alusrca    = ctrl.alusrca;
  assign alusrcb    = ctrl.alusrcb;
  assign pcsrc      = ctrl.pcsrc;
  assign regdst     = ctrl.regdst;
  assign memtoreg   = ctrl.memtoreg;
  assign illop      = illop_q;
  assign memtimeout = memtimeout_q;

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle MIPS main controller: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback, and drives datapath enables and muxes. It sits directly upstream of the ALU decoder: it forwards `op` and produces the 2-bit `aluop` that the ALU decoder turns into `alucontrol`. It also handles the optional memory-ready handshake and flags unsupported opcodes.

## Interface
- `MEM_WAIT_CYCLES_MAX`, 15: watchdog bound on consecutive `memready` waits; 0 disables the watchdog.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `op` in 6: instruction opcode from the instruction register.
- `memready` in 1: memory access complete; used only with `MEM_WAIT_EN`.
- `aluop` out 2: 00 add, 01 sub, 10 R-type (funct), 11 I-type (op).
- `irwrite`, `pcwrite`, `regwrite`, `memwrite` out 1 each: write strobes.
- `branch` out 1: beq, taken if `zero`.
- `branchgt` out 1: bgtz, taken if rs > 0.
- `iord` out 1: memory address source; 1 selects ALUOut.
- `alusrca` out 1: 1 selects rs.
- `alusrcb` out 2: 00 rt, 01 constant 4, 10 signimm, 11 signimm<<2.
- `pcsrc` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `regdst` out 1: 1 selects rd.
- `memtoreg` out 1: 1 selects the data register.
- `illop` out 1: one-cycle pulse for an unsupported opcode.
- `memtimeout` out 1: sticky watchdog flag.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEX, ALUWB, BEQ, ADDIEX, IMMEX, IMMWB, JUMP, BGTZ.
- FETCH:
  - `iord`=0, `alusrca`=0, `alusrcb`=01, `aluop`=00, `pcsrc`=00.
  - `irwrite`=1, `pcwrite`=1.
  - Next state DECODE.
- DECODE: `alusrcb`=11, `aluop`=00. Dispatches on `op`:
  - 100011 (lw) and 101011 (sw) → MEMADR.
  - 000000 (R-type) → RTEX.
  - 000100 (beq) → BEQ.
  - 001000 (addi) → ADDIEX.
  - 001110 (xori), 001111 (lui), 010001 (li) → IMMEX.
  - 011101 (bgtz) → BGTZ.
  - 000010 (j) → JUMP.
  - Any other opcode → FETCH, with `illop` pulsed in the following cycle.
- MEMADR: `alusrca`=1, `alusrcb`=10, `aluop`=00. lw → MEMRD; sw → MEMWR.
- MEMRD: `iord`=1. Next state MEMWB.
- MEMWB: `regdst`=0, `memtoreg`=1, `regwrite`=1. Next state FETCH.
- MEMWR: `iord`=1, `memwrite`=1. Next state FETCH.
- RTEX: `alusrca`=1, `alusrcb`=00, `aluop`=10. Next state ALUWB.
- ALUWB: `regdst`=1, `memtoreg`=0, `regwrite`=1. Next state FETCH.
- ADDIEX: `alusrca`=1, `alusrcb`=10, `aluop`=00. Next state IMMWB.
- IMMEX: `alusrca`=1, `alusrcb`=10, `aluop`=11. Next state IMMWB.
- IMMWB: `regdst`=0, `memtoreg`=0, `regwrite`=1. Next state FETCH.
- BEQ: `alusrca`=1, `alusrcb`=00, `aluop`=01, `pcsrc`=01, `branch`=1. Next state FETCH.
- BGTZ: `alusrca`=1, `alusrcb`=00, `aluop`=11, `pcsrc`=01, `branchgt`=1. Next state FETCH.
- JUMP: `pcsrc`=10, `pcwrite`=1. Next state FETCH.
- Every output not listed for a state is 0.
- State outputs are a pure function of the state register. `illop` is registered.

## Timing
- Cycle counts:
  - lw: 5 cycles.
  - sw, R-type, addi, xori, lui, li: 4 cycles.
  - beq, bgtz, j: 3 cycles.
  - Illegal opcode: 2 cycles.
- Reset:
  - While `reset_n`=0: state=FETCH, every strobe (`irwrite`, `pcwrite`, `regwrite`, `memwrite`, `branch`, `branchgt`) forced to 0, `illop`=0, `memtimeout`=0.
  - Mux outputs show their FETCH values.
- Deassertion: the first rising edge with `reset_n`=1 performs a real FETCH.
- Reset mid-instruction: abandon the instruction immediately and return to FETCH. No partial write completes after reset asserts.

## Configuration
- `MEM_WAIT_EN` defined:
  - FETCH, MEMRD and MEMWR hold state with all strobes deasserted until `memready`=1. The strobes assert only in the cycle where `memready`=1.
  - The wait counter increments each waiting cycle and clears on `memready`.
  - When the counter reaches `MEM_WAIT_CYCLES_MAX`, `memtimeout` sets and the FSM returns to FETCH. Only reset clears it.
- `MEM_WAIT_EN` undefined: `memready` is ignored, `memtimeout` is tied to 0, and the cycle counts above are exact.

## Structure
- `mips_ctrl_pkg` holds:
  - The state enum `mc_state_t`.
  - Opcode localparams (`OP_LW`, `OP_SW`, `OP_RTYPE`, `OP_BEQ`, `OP_ADDI`, `OP_XORI`, `OP_LUI`, `OP_LI`, `OP_BGTZ`, `OP_J`).
  - `aluop` localparams (`ALUOP_ADD`, `ALUOP_SUB`, `ALUOP_FUNCT`, `ALUOP_IMM`).
  - The control-word struct `mc_ctrl_t`.
- Sub-module `mc_outdec` maps state to `mc_ctrl_t` combinationally. `mc_ctrl` owns the state register, next-state logic, the wait counter and `illop`.

## Test plan
- lw (op=100011): states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles; `regwrite`=1 with `memtoreg`=1 only in cycle 5.
- xori (op=001110): `aluop`=11 in cycle 3; `regwrite`=1 with `regdst`=0 in cycle 4; back to FETCH in cycle 5.
- op=111111: `illop`=1 for exactly one cycle and no write strobe fires. Then beq (op=000100): `aluop`=01 and `branch`=1 in cycle 3.
- Assert `reset_n`=0 during MEMWR of sw: `memwrite` falls to 0 asynchronously; after release, FETCH with `pcwrite`=1.
- `MEM_WAIT_EN`, `memready` low for 3 cycles in MEMRD: state held, strobes 0; lw completes in 8 cycles total.
- `MEM_WAIT_EN`, `memready` held 0, `MEM_WAIT_CYCLES_MAX`=4: `memtimeout` rises after 4 wait cycles and the FSM returns to FETCH.
